// File: rtl/bsg_mem_1rw_byte_mask_requester.sv
`default_nettype none
// ============================================================================
// Module      : bsg_mem_1rw_byte_mask_requester
// Description : Initiator for a 1RW byte-masked hard SRAM. Issues one access
//               per cycle from a ready/valid request port, returns read data
//               through a 2-entry valid/yumi buffer, and optionally zero-fills
//               the whole array after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_mem_1rw_byte_mask_requester #(
    parameter int els_p        = 1024,
    parameter int addr_width_p = 10,
    parameter int width_p      = 32,
    parameter int init_p       = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,

    input  logic                    req_v_i,
    input  logic                    req_w_i,
    input  logic [addr_width_p-1:0] req_addr_i,
    input  logic [width_p-1:0]      req_data_i,
    input  logic [width_p/8-1:0]    req_mask_i,
    output logic                    req_ready_o,

    output logic                    resp_v_o,
    output logic [width_p-1:0]      resp_data_o,
    input  logic                    resp_yumi_i,

    output logic                    mem_v_o,
    output logic                    mem_w_o,
    output logic [addr_width_p-1:0] mem_addr_o,
    output logic [width_p-1:0]      mem_data_o,
    output logic [width_p-1:0]      mem_write_mask_o,
    input  logic [width_p-1:0]      mem_data_i,

    output logic                    init_done_o
);

    localparam int                    c_mask_w    = width_p / 8;
    localparam logic [0:0]            c_st_init   = 1'b0;
    localparam logic [0:0]            c_st_run    = 1'b1;
    localparam logic [0:0]            c_st_reset  = (init_p != 0) ? c_st_init : c_st_run;
    localparam logic [addr_width_p-1:0] c_last_addr = addr_width_p'(els_p - 1);

    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;
    logic [addr_width_p-1:0] r_init_cnt;

    logic                    r_pending;
    logic [1:0]              r_count;
    logic                    r_rd_ptr;
    logic                    r_wr_ptr;
    logic [width_p-1:0]      r_buf [0:1];

    logic                    w_run;
    logic                    w_init;
    logic                    w_resp_v;
    logic                    w_pop;
    logic                    w_push;
    logic [2:0]              w_occ;
    logic [2:0]              w_credit;
    logic                    w_ready;
    logic                    w_accept;
    logic [width_p-1:0]      w_mask_exp;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= c_st_reset;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == c_st_init && r_init_cnt == c_last_addr) begin
            w_state_nxt = c_st_run;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_init_cnt <= '0;
        end else if (r_state == c_st_init) begin
            r_init_cnt <= r_init_cnt + addr_width_p'(1);
        end
    end

    // ------------------------------------------------------------------
    // Byte mask to bit mask expansion
    // ------------------------------------------------------------------
    for (genvar b = 0; b < c_mask_w; b++) begin : g_mask
        assign w_mask_exp[8*b +: 8] = {8{req_mask_i[b]}};
    end

    // ------------------------------------------------------------------
    // Credit and handshake
    // ------------------------------------------------------------------
    // Reset gates every valid/ready so nothing escapes during the reset cycle.
    assign w_run    = ~reset_i & (r_state == c_st_run);
    assign w_init   = ~reset_i & (r_state == c_st_init);
    assign w_resp_v = ~reset_i & (r_count != 2'd0);
    assign w_pop    = resp_yumi_i & w_resp_v;
    assign w_push   = r_pending;

    // A consumer pop this cycle frees a slot, hence the yumi->ready path.
    assign w_occ    = {1'b0, r_count} + {2'b00, r_pending};
    assign w_credit = w_occ - {2'b00, w_pop};
    assign w_ready  = w_run & (w_credit < 3'd2);
    assign w_accept = req_v_i & w_ready;

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        mem_v_o          = 1'b0;
        mem_w_o          = 1'b0;
        mem_addr_o       = '0;
        mem_data_o       = '0;
        mem_write_mask_o = '0;
        if (w_init) begin
            mem_v_o          = 1'b1;
            mem_w_o          = 1'b1;
            mem_addr_o       = r_init_cnt;
            mem_write_mask_o = '1;
        end else if (w_accept) begin
            mem_v_o    = 1'b1;
            mem_w_o    = req_w_i;
            mem_addr_o = req_addr_i;
            if (req_w_i) begin
                mem_data_o       = req_data_i;
                mem_write_mask_o = w_mask_exp;
            end
        end
    end

    assign req_ready_o = w_ready;
    assign init_done_o = w_run;
    assign resp_v_o    = w_resp_v;
    assign resp_data_o = r_buf[r_rd_ptr];

    // ------------------------------------------------------------------
    // Pending read flag and response buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_pending <= 1'b0;
            r_count   <= 2'd0;
            r_rd_ptr  <= 1'b0;
            r_wr_ptr  <= 1'b0;
        end else begin
            r_pending <= w_accept & ~req_w_i;
            r_count   <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    // SRAM read data is only valid the cycle after issue; capture it then.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_buf[r_wr_ptr] <= mem_data_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bsg_mem_1rw_byte_mask_requester.sv
`default_nettype none
// Testbench for bsg_mem_1rw_byte_mask_requester: directed vectors against a
// behavioural byte-masked SRAM, plus a second instance with init_p=0.
module tb_bsg_mem_1rw_byte_mask_requester;

    localparam int ELS = 1024;
    localparam int AW  = 10;
    localparam int W   = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A (init_p=1)
    logic          reset_a;
    logic          req_v, req_w, req_ready;
    logic [AW-1:0] req_addr;
    logic [W-1:0]  req_data;
    logic [3:0]    req_mask;
    logic          resp_v, resp_yumi;
    logic [W-1:0]  resp_data;
    logic          mem_v, mem_w;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata, mem_wmask, mem_rdata;
    logic          init_done;

    // Instance B (init_p=0)
    logic          reset_b;
    logic          b_ready, b_resp_v, b_mem_v, b_mem_w, b_done;
    logic [W-1:0]  b_resp_data, b_mem_data, b_mem_mask;
    logic [AW-1:0] b_mem_addr;

    bsg_mem_1rw_byte_mask_requester #(
        .els_p(ELS), .addr_width_p(AW), .width_p(W), .init_p(1)
    ) dut_a (
        .clk_i(clk), .reset_i(reset_a),
        .req_v_i(req_v), .req_w_i(req_w), .req_addr_i(req_addr),
        .req_data_i(req_data), .req_mask_i(req_mask), .req_ready_o(req_ready),
        .resp_v_o(resp_v), .resp_data_o(resp_data), .resp_yumi_i(resp_yumi),
        .mem_v_o(mem_v), .mem_w_o(mem_w), .mem_addr_o(mem_addr),
        .mem_data_o(mem_wdata), .mem_write_mask_o(mem_wmask), .mem_data_i(mem_rdata),
        .init_done_o(init_done)
    );

    bsg_mem_1rw_byte_mask_requester #(
        .els_p(ELS), .addr_width_p(AW), .width_p(W), .init_p(0)
    ) dut_b (
        .clk_i(clk), .reset_i(reset_b),
        .req_v_i(1'b0), .req_w_i(1'b0), .req_addr_i('0),
        .req_data_i('0), .req_mask_i(4'h0), .req_ready_o(b_ready),
        .resp_v_o(b_resp_v), .resp_data_o(b_resp_data), .resp_yumi_i(1'b0),
        .mem_v_o(b_mem_v), .mem_w_o(b_mem_w), .mem_addr_o(b_mem_addr),
        .mem_data_o(b_mem_data), .mem_write_mask_o(b_mem_mask), .mem_data_i(32'h0),
        .init_done_o(b_done)
    );

    // Behavioural SRAM, pre-seeded with garbage so the zero-fill is observable.
    logic [W-1:0] sram [0:ELS-1];
    initial begin
        for (int i = 0; i < ELS; i++) sram[i] = 32'hDEADBEEF;
        mem_rdata = 32'h0;
    end
    always @(posedge clk) begin
        if (mem_v) begin
            if (mem_w) sram[mem_addr] = (sram[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
            else       mem_rdata <= sram[mem_addr];
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int b_bad = 0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wdat(input int k);
        return 32'hA5000000 + 32'(k) * 32'h00010101;
    endfunction

    function automatic logic [31:0] exp_word(input int a);
        case (a)
            1, 2, 3, 4: return wdat(a);
            5:          return 32'h00BB00DD;
            6:          return 32'h12000000;
            default:    return 32'h0;
        endcase
    endfunction

    // Watches one full INIT pass; caller is at the first INIT cycle (posedge+1).
    task automatic run_init(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < ELS; i++) begin
            #3;
            if (!(mem_v === 1'b1 && mem_w === 1'b1 && mem_addr === AW'(i) &&
                  mem_wdata === 32'h0 && mem_wmask === 32'hFFFFFFFF &&
                  req_ready === 1'b0 && init_done === 1'b0 && resp_v === 1'b0)) bad++;
            if (b_mem_v !== 1'b0 || b_ready !== 1'b1 || b_done !== 1'b1) b_bad++;
            if (i == 0)       check_vec({tag, "_first_addr"}, 32'(mem_addr), 32'd0);
            if (i == ELS - 1) check_vec({tag, "_last_addr"}, 32'(mem_addr), 32'(ELS - 1));
            next_cycle();
        end
        check_vec({tag, "_seq_bad_cycles"}, 32'(bad), 32'd0);
        #3;
        check_vec({tag, "_done"}, {31'b0, init_done}, 32'd1);
        check_vec({tag, "_ready_after"}, {31'b0, req_ready}, 32'd1);
        check_vec({tag, "_mem_idle_after"}, {31'b0, mem_v}, 32'd0);
        next_cycle();
    endtask

    task automatic write_word(input int a, input logic [31:0] d, input logic [3:0] m);
        req_v = 1'b1; req_w = 1'b1; req_addr = AW'(a); req_data = d; req_mask = m;
        #3;
        check_vec("wr_ready", {31'b0, req_ready}, 32'd1);
        next_cycle();
        req_v = 1'b0;
    endtask

    initial begin
        reset_a = 1'b1; reset_b = 1'b1;
        req_v = 1'b0; req_w = 1'b0; req_addr = '0; req_data = '0; req_mask = '0;
        resp_yumi = 1'b0;

        // Reset held for two edges
        next_cycle();
        #3;
        check_vec("rst_outputs_a", {28'b0, req_ready, resp_v, mem_v, init_done}, 32'd0);
        check_vec("rst_outputs_b", {28'b0, b_ready, b_resp_v, b_mem_v, b_done}, 32'd0);
        next_cycle();
        reset_a = 1'b0; reset_b = 1'b0;

        // Zero-fill; instance B must be ready immediately and never touch memory
        run_init("init1");
        check_vec("b_no_init_writes", 32'(b_bad), 32'd0);

        // Masked write to 5, read 5, write to 6 in the cycle after the read
        req_v = 1'b1; req_w = 1'b1; req_addr = 10'd5; req_data = 32'hAABBCCDD; req_mask = 4'b0101;
        #3;
        check_vec("t2_wr_ctl", {28'b0, req_ready, mem_v, mem_w, 1'b0}, 32'hE);
        check_vec("t2_wr_addr", 32'(mem_addr), 32'd5);
        check_vec("t2_wr_mask", mem_wmask, 32'h00FF00FF);
        check_vec("t2_wr_data", mem_wdata, 32'hAABBCCDD);
        next_cycle();
        req_w = 1'b0;
        #3;
        check_vec("t2_rd_ctl", {29'b0, req_ready, mem_v, mem_w}, 32'h6);
        check_vec("t2_rd_mask", mem_wmask, 32'h0);
        check_vec("t2_rd_data", mem_wdata, 32'h0);
        next_cycle();
        req_w = 1'b1; req_addr = 10'd6; req_data = 32'h12345678; req_mask = 4'b1000;
        #3;
        check_vec("t2_resp_not_early", {31'b0, resp_v}, 32'd0);
        check_vec("t2_wr6_mask", mem_wmask, 32'hFF000000);
        next_cycle();
        req_v = 1'b0;
        resp_yumi = 1'b1;
        #3;
        check_vec("t2_resp_v", {31'b0, resp_v}, 32'd1);
        check_vec("t2_resp_data", resp_data, 32'h00BB00DD);
        next_cycle();
        resp_yumi = 1'b0;
        #3;
        check_vec("t2_resp_drained", {31'b0, resp_v}, 32'd0);
        next_cycle();

        for (int k = 1; k <= 4; k++) write_word(k, wdat(k), 4'hF);

        // Backpressure: reads 1..4 with yumi low, then drain in order
        req_v = 1'b1; req_w = 1'b0; req_addr = 10'd1;
        #3; check_vec("t3_acc1", {31'b0, req_ready}, 32'd1);
        next_cycle();
        req_addr = 10'd2;
        #3; check_vec("t3_acc2", {31'b0, req_ready}, 32'd1);
        next_cycle();
        req_addr = 10'd3;
        #3;
        check_vec("t3_ready_drop", {31'b0, req_ready}, 32'd0);
        check_vec("t3_no_issue", {31'b0, mem_v}, 32'd0);
        check_vec("t3_head1", resp_data, wdat(1));
        next_cycle();
        #3; check_vec("t3_still_stalled", {31'b0, req_ready}, 32'd0);
        next_cycle();
        resp_yumi = 1'b1;
        #3;
        check_vec("t3_yumi_ready", {31'b0, req_ready}, 32'd1);
        check_vec("t3_data1", resp_data, wdat(1));
        next_cycle();
        req_addr = 10'd4;
        #3;
        check_vec("t3_acc4", {31'b0, req_ready}, 32'd1);
        check_vec("t3_data2", resp_data, wdat(2));
        next_cycle();
        req_v = 1'b0;
        #3; check_vec("t3_data3", {resp_v ? resp_data : 32'hFFFFFFFF}, wdat(3));
        next_cycle();
        #3; check_vec("t3_data4", {resp_v ? resp_data : 32'hFFFFFFFF}, wdat(4));
        next_cycle();
        resp_yumi = 1'b0;
        #3; check_vec("t3_empty", {31'b0, resp_v}, 32'd0);
        next_cycle();

        // Streaming reads 0..15, consumer always taking
        for (int s = 0; s < 18; s++) begin
            req_v = (s < 16); req_w = 1'b0; req_addr = AW'(s);
            resp_yumi = (s >= 2);
            #3;
            if (s < 16) check_vec($sformatf("t4_ready_%0d", s), {31'b0, req_ready}, 32'd1);
            check_vec($sformatf("t4_resp_v_%0d", s), {31'b0, resp_v}, {31'b0, s >= 2});
            if (s >= 2) check_vec($sformatf("t4_data_%0d", s - 2), resp_data, exp_word(s - 2));
            next_cycle();
        end
        req_v = 1'b0; resp_yumi = 1'b0;
        #3; check_vec("t4_empty", {31'b0, resp_v}, 32'd0);
        next_cycle();

        // Reset with one response buffered and one read pending
        req_v = 1'b1; req_w = 1'b0; req_addr = 10'd1;
        next_cycle();
        req_addr = 10'd2;
        next_cycle();
        req_v = 1'b0;
        reset_a = 1'b1;
        #3;
        check_vec("t5_rst_gate", {28'b0, req_ready, resp_v, mem_v, init_done}, 32'd0);
        next_cycle();
        reset_a = 1'b0;
        run_init("init2");
        #3; check_vec("t5_no_stale", {31'b0, resp_v}, 32'd0);
        req_v = 1'b1; req_w = 1'b0; req_addr = 10'd1;
        next_cycle();
        req_v = 1'b0;
        next_cycle();
        resp_yumi = 1'b1;
        #3;
        check_vec("t5_refill_v", {31'b0, resp_v}, 32'd1);
        check_vec("t5_refill_data", resp_data, 32'h0);
        next_cycle();
        resp_yumi = 1'b0;
        #3; check_vec("t5_final_empty", {31'b0, resp_v}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
